// File: rtl/perf_pkg.sv
// Shared constants and types for the perf counter MMIO window.
// Offset decode is here so the window map is described in one place.
package perf_pkg;

    localparam logic [31:0] BASE_ADDR_DEF    = 32'hFFFF_FF00;
    localparam int          NUM_COUNTERS_DEF = 9;
    localparam int          SEL_WIDTH_DEF    = 5;

    localparam logic [7:0] LIVE_BASE = 8'h00;
    localparam logic [7:0] SNAP_BASE = 8'h40;
    localparam logic [7:0] CTRL_OFF  = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        SCAN
    } perf_bridge_state_t;

    typedef enum logic [1:0] {
        REG_LIVE,
        REG_SNAP,
        REG_CTRL,
        REG_NONE
    } perf_region_t;

    // Only word-aligned offsets of existing counters map to registers.
    function automatic perf_region_t decode_off(
        input logic [7:0] off,
        input int         num
    );
        perf_region_t r;
        r = REG_NONE;
        if (off[1:0] == 2'b00) begin
            if (off == CTRL_OFF) begin
                r = REG_CTRL;
            end else if (off[7:6] == LIVE_BASE[7:6] && int'(off[5:2]) < num) begin
                r = REG_LIVE;
            end else if (off[7:6] == SNAP_BASE[7:6] && int'(off[5:2]) < num) begin
                r = REG_SNAP;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/perf_snapshot_bank.sv
// Frozen copy of the counter bank, filled one entry per cycle by a scan.
// Cleared synchronously whenever rst_n is low.
module perf_snapshot_bank
    import perf_pkg::*;
#(
    parameter int NUM_COUNTERS = NUM_COUNTERS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [3:0]  widx_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  ridx_i,
    output logic [31:0] rdata_o
);

    logic [31:0] snap_q [NUM_COUNTERS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                snap_q[i] <= '0;
            end
        end else if (we_i && int'(widx_i) < NUM_COUNTERS) begin
            snap_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = (int'(ridx_i) < NUM_COUNTERS) ? snap_q[ridx_i] : '0;

endmodule

// File: rtl/perf_mmio_bridge.sv
// Load/store bridge: serves the perf counter window locally and
// forwards every other access to the L1D with no added latency.
module perf_mmio_bridge
    import perf_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
    parameter int          NUM_COUNTERS = NUM_COUNTERS_DEF,
    parameter int          SEL_WIDTH    = SEL_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          mem_address,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_byte_enable,
    output logic                 mem_resp,
    output logic [31:0]          mem_rdata,
    output logic                 dcache_read,
    output logic                 dcache_write,
    output logic [31:0]          dcache_address,
    output logic [31:0]          dcache_wdata,
    output logic [3:0]           dcache_byte_enable,
    input  logic                 dcache_resp,
    input  logic [31:0]          dcache_rdata,
    output logic [SEL_WIDTH-1:0] pc_read_src,
    input  logic [31:0]          pc_read_data
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_COUNTERS - 1);

    perf_bridge_state_t state_q, state_d;
    logic [3:0]         scan_idx_q, scan_idx_d;
    logic [7:0]         off_q, off_d;
    logic               wr_q, wr_d;
    logic               go_q, go_d;

    logic                 hit;
    logic                 busy;
    perf_region_t         region;
    logic [SEL_WIDTH-1:0] src;
    logic                 loc_resp;
    logic [31:0]          loc_rdata;
    logic                 snap_we;
    logic [31:0]          snap_rdata;

    assign hit = (mem_read | mem_write)
               && (mem_address[31:8] == BASE_ADDR[31:8]);
    assign busy   = (state_q == SCAN);
    assign region = decode_off(off_q, NUM_COUNTERS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
            off_q      <= '0;
            wr_q       <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            off_q      <= off_d;
            wr_q       <= wr_d;
            go_q       <= go_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        off_d      = off_q;
        wr_d       = wr_q;
        go_d       = go_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = RESP;
                    off_d   = mem_address[7:0];
                    wr_d    = mem_write;
                    go_d    = mem_write
                            && mem_address[7:0] == CTRL_OFF
                            && mem_wdata[0];
                end
            end
            RESP: begin
                scan_idx_d = '0;
                state_d    = go_q ? SCAN : IDLE;
            end
            SCAN: begin
                scan_idx_d = scan_idx_q + 4'd1;
                if (scan_idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src       = '0;
        loc_resp  = 1'b0;
        loc_rdata = '0;
        snap_we   = 1'b0;
        unique case (state_q)
            RESP: begin
                loc_resp = 1'b1;
                if (!wr_q) begin
                    unique case (region)
                        REG_LIVE: begin
                            src       = SEL_WIDTH'(off_q[5:2]);
                            loc_rdata = pc_read_data;
                        end
                        REG_SNAP: loc_rdata = snap_rdata;
                        REG_CTRL: loc_rdata = {31'b0, busy};
                        default:  loc_rdata = '0;
                    endcase
                end
            end
            SCAN: begin
                src     = SEL_WIDTH'(scan_idx_q);
                snap_we = 1'b1;
            end
            default: src = '0;
        endcase
    end

    perf_snapshot_bank #(
        .NUM_COUNTERS (NUM_COUNTERS)
    ) u_snap (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (snap_we),
        .widx_i  (scan_idx_q),
        .wdata_i (pc_read_data),
        .ridx_i  (off_q[5:2]),
        .rdata_o (snap_rdata)
    );

    // Outputs are forced quiet while reset is held.
    assign pc_read_src  = rst_n ? src : '0;
    assign mem_resp     = rst_n & (loc_resp | (~hit & dcache_resp));
    assign mem_rdata    = loc_resp ? loc_rdata : dcache_rdata;
    assign dcache_read  = rst_n & mem_read & ~hit;
    assign dcache_write = rst_n & mem_write & ~hit;

    assign dcache_address     = mem_address;
    assign dcache_wdata       = mem_wdata;
    assign dcache_byte_enable = mem_byte_enable;

endmodule

// File: tb/tb_perf_mmio_bridge.sv
// Directed bench for perf_mmio_bridge with a cycle-indexed reference model.
// Counters are a pure function of (index, cycle) so snapshot skew is predictable.
module tb_perf_mmio_bridge;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int          NC   = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_byte_enable = '0;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        dcache_read;
    logic        dcache_write;
    logic [31:0] dcache_address;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_byte_enable;
    logic        dcache_resp = 1'b0;
    logic [31:0] dcache_rdata = '0;
    logic [4:0]  pc_read_src;
    logic [31:0] pc_read_data;

    perf_mmio_bridge dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_address        (mem_address),
        .mem_wdata          (mem_wdata),
        .mem_byte_enable    (mem_byte_enable),
        .mem_resp           (mem_resp),
        .mem_rdata          (mem_rdata),
        .dcache_read        (dcache_read),
        .dcache_write       (dcache_write),
        .dcache_address     (dcache_address),
        .dcache_wdata       (dcache_wdata),
        .dcache_byte_enable (dcache_byte_enable),
        .dcache_resp        (dcache_resp),
        .dcache_rdata       (dcache_rdata),
        .pc_read_src        (pc_read_src),
        .pc_read_data       (pc_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] base_v [NC];
    bit          run = 1'b0;

    always_comb begin
        pc_read_data = 32'h0;
        if (int'(pc_read_src) < NC) begin
            pc_read_data = base_v[pc_read_src[3:0]] + (run ? 32'(cyc) : 32'h0);
        end
    end

    logic [31:0] snap_m [NC];
    int          scan_start = -1;
    int          exp_resp_cyc = -1;
    logic [31:0] exp_rdata = '0;
    bit          exp_chk = 1'b0;
    logic [4:0]  exp_src = '0;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mval(input int k, input int c);
        return base_v[k] + (run ? 32'(c) : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit         hit_e;
        bit         loc;
        logic [4:0] src_e;
        if (!rst_n) begin
            chk("rst_resp", 32'(mem_resp), 32'h0);
            chk("rst_src", 32'(pc_read_src), 32'h0);
            chk("rst_dcread", 32'(dcache_read), 32'h0);
            chk("rst_dcwrite", 32'(dcache_write), 32'h0);
        end else begin
            hit_e = (mem_read || mem_write) && mem_address[31:8] == BASE[31:8];
            loc   = (cyc == exp_resp_cyc);
            chk("resp", 32'(mem_resp), 32'(loc || (!hit_e && dcache_resp)));
            if (loc && exp_chk) chk("rdata", mem_rdata, exp_rdata);
            if (!hit_e && dcache_resp) chk("pt_rdata", mem_rdata, dcache_rdata);
            chk("dcread", 32'(dcache_read), 32'(mem_read && !hit_e));
            chk("dcwrite", 32'(dcache_write), 32'(mem_write && !hit_e));
            if (!hit_e) begin
                chk("dcaddr", dcache_address, mem_address);
                chk("dcwdata", dcache_wdata, mem_wdata);
                chk("dcbe", 32'(dcache_byte_enable), 32'(mem_byte_enable));
            end
            if (scan_start >= 0 && cyc >= scan_start && cyc < scan_start + NC)
                src_e = 5'(cyc - scan_start);
            else if (loc)
                src_e = exp_src;
            else
                src_e = 5'd0;
            chk("src", 32'(pc_read_src), 32'(src_e));
        end
    end

    task automatic idle_inputs();
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = '0;
        mem_wdata = '0;
        mem_byte_enable = '0;
    endtask

    task automatic win(input bit rd, input bit wr, input logic [7:0] off,
                       input logic [31:0] wd, output logic [31:0] got,
                       output int lat, output logic [4:0] src);
        int n;
        int r;
        int k;
        bit done;
        @(posedge clk); #1;
        n = cyc;
        mem_read = rd;
        mem_write = wr;
        mem_address = BASE | 32'(off);
        mem_wdata = wd;
        mem_byte_enable = 4'b0001;
        r = n + 1;
        if (scan_start >= 0 && n < scan_start + NC) r = scan_start + NC + 1;
        k = int'(off[5:2]);
        exp_chk = !wr;
        exp_src = 5'd0;
        exp_rdata = 32'h0;
        if (!wr && off[1:0] == 2'b00) begin
            if (off < 8'h40 && k < NC) begin
                exp_src = 5'(k);
                exp_rdata = mval(k, r);
            end else if (off >= 8'h40 && off < 8'h80 && k < NC) begin
                exp_rdata = snap_m[k];
            end else if (off == 8'h80) begin
                exp_rdata = 32'(scan_start >= 0 && r >= scan_start
                                && r < scan_start + NC);
            end
        end
        exp_resp_cyc = r;
        if (wr && off == 8'h80 && wd[0]) begin
            scan_start = r + 1;
            for (int i = 0; i < NC; i++) snap_m[i] = mval(i, r + 1 + i);
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_resp) done = 1'b1;
        end
        got = mem_rdata;
        src = pc_read_src;
        lat = cyc - n;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL win_timeout: no mem_resp for offset %h", off);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic pt_load(input logic [31:0] a, input logic [31:0] d,
                           input int delay, output logic [31:0] got,
                           output bit seen, output logic [4:0] src);
        @(posedge clk); #1;
        mem_read = 1'b1;
        mem_address = a;
        mem_byte_enable = 4'hF;
        repeat (delay) begin
            @(posedge clk); #1;
        end
        dcache_resp = 1'b1;
        dcache_rdata = d;
        @(negedge clk);
        seen = mem_resp;
        got = mem_rdata;
        src = pc_read_src;
        @(posedge clk); #1;
        dcache_resp = 1'b0;
        dcache_rdata = '0;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g;
        logic [31:0] g0;
        logic [31:0] g2;
        logic [4:0]  s;
        int          lat;
        bit          seen;

        for (int i = 0; i < NC; i++) begin
            base_v[i] = 32'(i) * 32'h1000;
            snap_m[i] = 32'h0;
        end
        base_v[6] = 32'd42;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        win(1'b1, 1'b0, 8'h40, 32'h0, g, lat, s);
        chk("reset_snap0", g, 32'h0);

        // Pass-through with L1D answering three cycles later
        pt_load(32'h0000_1000, 32'hDEAD_BEEF, 3, g, seen, s);
        chk("pt_seen", 32'(seen), 32'h1);
        chk("pt_data", g, 32'hDEAD_BEEF);
        chk("pt_src", 32'(s), 32'h0);

        win(1'b1, 1'b0, 8'h18, 32'h0, g, lat, s);
        chk("live6_data", g, 32'd42);
        chk("live6_lat", 32'(lat), 32'd1);
        chk("live6_src", 32'(s), 32'd6);

        // Free-running counters for snapshot skew
        base_v[6] = 32'h6000;
        run = 1'b1;
        win(1'b0, 1'b1, 8'h80, 32'h1, g, lat, s);
        chk("start_lat", 32'(lat), 32'd1);
        win(1'b1, 1'b0, 8'h40, 32'h0, g0, lat, s);
        win(1'b1, 1'b0, 8'h48, 32'h0, g2, lat, s);
        chk("snap_skew", (g2 - 32'h2000) - g0, 32'd2);

        win(1'b1, 1'b0, 8'hF0, 32'h0, g, lat, s);
        chk("unmapped", g, 32'h0);
        win(1'b1, 1'b0, 8'h44, 32'h0, g0, lat, s);
        win(1'b0, 1'b1, 8'h44, 32'hFFFF_FFFF, g, lat, s);
        chk("snap_store_lat", 32'(lat), 32'd1);
        win(1'b1, 1'b0, 8'h44, 32'h0, g, lat, s);
        chk("snap1_kept", g, g0);

        // Read and write together: write wins and starts a scan
        win(1'b1, 1'b1, 8'h80, 32'h1, g, lat, s);
        win(1'b1, 1'b0, 8'h80, 32'h0, g, lat, s);
        chk("stall_lat", 32'(lat), 32'd9);
        chk("stall_ctrl", g, 32'h0);

        win(1'b0, 1'b1, 8'h80, 32'h1, g, lat, s);
        pt_load(32'h0000_2000, 32'h1234_5678, 1, g, seen, s);
        chk("scan_pt_seen", 32'(seen), 32'h1);
        chk("scan_pt_data", g, 32'h1234_5678);
        repeat (12) @(posedge clk);

        // Reset while scan_idx is 4
        win(1'b0, 1'b1, 8'h80, 32'h1, g, lat, s);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        scan_start = -1;
        exp_resp_cyc = -1;
        for (int i = 0; i < NC; i++) snap_m[i] = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        win(1'b1, 1'b0, 8'h40, 32'h0, g, lat, s);
        chk("rst_snap0", g, 32'h0);
        win(1'b1, 1'b0, 8'h4C, 32'h0, g, lat, s);
        chk("rst_snap3", g, 32'h0);
        win(1'b1, 1'b0, 8'h60, 32'h0, g, lat, s);
        chk("rst_snap8", g, 32'h0);
        win(1'b1, 1'b0, 8'h80, 32'h0, g, lat, s);
        chk("rst_busy", g, 32'h0);
        chk("rst_busy_lat", 32'(lat), 32'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
